// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU fetch stage and its decoder interface.
package cpu_pkg;

  localparam int unsigned IW      = 16;
  localparam int unsigned OFF_LSB = 0;
  localparam int unsigned OFF_MSB = 7;
  localparam int unsigned OFF_W   = OFF_MSB - OFF_LSB + 1;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_JUMP   = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/cpu_pc_next.sv
// Next-PC selection: hold, increment, PC-relative branch or absolute jump, wrapping modulo 2^AW.
module cpu_pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic [AW-1:0]    pc,
  input  logic [1:0]       ps,
  input  logic [OFF_W-1:0] ir_off,
  input  logic [AW-1:0]    jump_addr,
  output logic [AW-1:0]    next_pc
);

  logic [AW-1:0] off_sext;

  // Sizing a signed operand replicates its sign bit into the upper bits.
  assign off_sext = AW'($signed(ir_off));

  always_comb begin
    next_pc = pc;
    case (ps_e'(ps))
      PS_HOLD:   next_pc = pc;
      PS_INC:    next_pc = pc + AW'(1);
      PS_BRANCH: next_pc = pc + AW'(1) + off_sext;
      PS_JUMP:   next_pc = jump_addr;
    endcase
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch stage: owns PC, IR and the decoder State bit; fetches over req/ack
// and applies the decoder's PS / IR_L / NS controls.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    ps,
  input  logic          ir_l,
  input  logic          ns,
  input  logic [AW-1:0] jump_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_ack,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] ir,
  output logic          state,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fetch_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_e  fsm_q, fsm_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] pc_next;

  cpu_pc_next #(
    .AW(AW)
  ) u_pc_next (
    .pc       (pc_q),
    .ps       (ps),
    .ir_off   (ir_q[OFF_MSB:OFF_LSB]),
    .jump_addr(jump_addr),
    .next_pc  (pc_next)
  );

  // State registers; reset wins over any in-flight fetch or execution.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (fsm_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = 1'b0;
          cnt_d   = '0;
          fsm_d   = EXEC;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          fsm_d = HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        // NS=1 holds the instruction for another decoder cycle; PS is ignored then.
        if (ns) begin
          state_d = 1'b1;
        end else if (ir_l) begin
          state_d = 1'b0;
          pc_d    = pc_next;
          fsm_d   = FETCH;
        end else begin
          state_d = 1'b0;
          fsm_d   = HALT;
        end
      end
      HALT: begin
        fsm_d = HALT;
      end
      default: begin
        fsm_d = HALT;
      end
    endcase
  end

  assign imem_req  = (fsm_q == FETCH);
  assign imem_addr = pc_q;
  assign ir_valid  = (fsm_q == EXEC);
  assign halted    = (fsm_q == HALT);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit against an instruction-level reference model.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ps = 2'b00;
  logic        ir_l = 1'b0;
  logic        ns = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] ir;
  logic        state;
  logic        ir_valid;
  logic [15:0] pc;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC/IR/State plus "fetching"/"halted"/"error" flags.
  int          m_pc;
  logic [15:0] m_ir;
  logic        m_st;
  logic        m_fetching;
  logic        m_halt;
  logic        m_err;

  cpu_fetch_unit #(
    .AW      (16),
    .RESET_PC(16'h0010),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps        (ps),
    .ir_l      (ir_l),
    .ns        (ns),
    .jump_addr (jump_addr),
    .imem_rdata(imem_rdata),
    .imem_ack  (imem_ack),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .ir        (ir),
    .state     (state),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next_pc(input logic [1:0] p, input logic [15:0] ja);
    logic [7:0] o;
    int off;
    o = m_ir[7:0];
    off = (o >= 8'd128) ? int'(o) - 256 : int'(o);
    case (p)
      2'b00:   return m_pc;
      2'b01:   return (m_pc + 1) & 'hFFFF;
      2'b10:   return (m_pc + 1 + off) & 'hFFFF;
      default: return int'(ja);
    endcase
  endfunction

  task automatic do_reset(input logic late_ack);
    reset = 1'b1;
    imem_ack = late_ack;
    imem_rdata = 16'hBEEF;
    clk_step();
    reset = 1'b0;
    imem_ack = 1'b0;
    m_pc = 'h0010; m_ir = 16'h0000; m_st = 1'b0;
    m_fetching = 1'b1; m_halt = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || pc !== 16'h0010 || ir !== 16'h0000 ||
        state !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h pc=%h ir=%h st=%b v=%b h=%b e=%b want req=1 addr=0010 pc=0010 ir=0000 st=0 v=0 h=0 e=0",
               tag, imem_req, imem_addr, pc, ir, state, ir_valid, halted, fetch_err);
    end
  endtask

  // Serve one fetch with `waits` idle cycles before the ack; checks the request each cycle.
  task automatic fetch_word(input int waits, input logic [15:0] word, input string tag);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(m_pc) || ir_valid !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL %s req cyc%0d: req=%b addr=%h v=%b h=%b want req=1 addr=%h v=0 h=0",
                 tag, i, imem_req, imem_addr, ir_valid, halted, 16'(m_pc));
      end
      imem_ack = (i == waits);
      imem_rdata = (i == waits) ? word : 16'($urandom);
      clk_step();
    end
    imem_ack = 1'b0;
    m_ir = word; m_st = 1'b0; m_fetching = 1'b0;
    checks++;
    if (ir !== word || ir_valid !== 1'b1 || imem_req !== 1'b0 || state !== 1'b0 || pc !== 16'(m_pc)) begin
      errors++;
      $display("FAIL %s load: ir=%h v=%b req=%b st=%b pc=%h want ir=%h v=1 req=0 st=0 pc=%h",
               tag, ir, ir_valid, imem_req, state, pc, word, 16'(m_pc));
    end
  endtask

  // One decoder cycle in EXEC, then compare against the model.
  task automatic exec_step(input logic [1:0] p, input logic il, input logic n,
                           input logic [15:0] ja, input string tag);
    ps = p; ir_l = il; ns = n; jump_addr = ja;
    clk_step();
    if (n) m_st = 1'b1;
    else if (il) begin m_st = 1'b0; m_pc = model_next_pc(p, ja); m_fetching = 1'b1; end
    else begin m_st = 1'b0; m_halt = 1'b1; end
    ps = 2'(($urandom)); ir_l = 1'b0; ns = 1'b0; jump_addr = 16'($urandom);
    checks++;
    if (state !== m_st || pc !== 16'(m_pc) || imem_addr !== 16'(m_pc) || ir !== m_ir ||
        imem_req !== m_fetching || halted !== m_halt ||
        ir_valid !== (!m_fetching && !m_halt)) begin
      errors++;
      $display("FAIL %s: st=%b pc=%h ir=%h req=%b h=%b v=%b want st=%b pc=%h ir=%h req=%b h=%b v=%b",
               tag, state, pc, ir, imem_req, halted, ir_valid, m_st, 16'(m_pc), m_ir,
               m_fetching, m_halt, !m_fetching && !m_halt);
    end
  endtask

  task automatic test_basic();
    fetch_word(2, 16'h1805, "basic_fetch");
    exec_step(2'b01, 1'b1, 1'b0, 16'h0000, "basic_inc");
    checks++;
    if (imem_addr !== 16'h0011 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_next: addr=%h req=%b want addr=0011 req=1", imem_addr, imem_req);
    end
  endtask

  task automatic test_branch();
    fetch_word(1, 16'h3000, "br_setup");
    exec_step(2'b11, 1'b1, 1'b0, 16'h0020, "br_jump20");
    fetch_word(0, 16'h42FC, "br_fetch");
    exec_step(2'b10, 1'b1, 1'b0, 16'h0000, "br_back");
    checks++;
    if (imem_addr !== 16'h001D) begin
      errors++;
      $display("FAIL br_target: addr=%h want 001D", imem_addr);
    end
    fetch_word(0, 16'h1111, "wrap_setup");
    exec_step(2'b11, 1'b1, 1'b0, 16'hFFFF, "wrap_jump");
    fetch_word(3, 16'h2222, "wrap_fetch");
    exec_step(2'b01, 1'b1, 1'b0, 16'h0000, "wrap_inc");
    checks++;
    if (imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_target: addr=%h want 0000", imem_addr);
    end
  endtask

  task automatic test_multicycle();
    fetch_word(1, 16'h7A05, "mc_fetch");
    exec_step(2'($urandom), 1'b1, 1'b1, 16'($urandom), "mc_hold1");
    exec_step(2'($urandom), 1'($urandom), 1'b1, 16'($urandom), "mc_hold2");
    exec_step(2'b11, 1'b1, 1'b0, 16'h0400, "mc_jump");
    checks++;
    if (pc !== 16'h0400 || imem_req !== 1'b1 || state !== 1'b0) begin
      errors++;
      $display("FAIL mc_final: pc=%h req=%b st=%b want pc=0400 req=1 st=0", pc, imem_req, state);
    end
  endtask

  task automatic test_halt();
    fetch_word(2, 16'h0F0F, "halt_fetch");
    exec_step(2'b01, 1'b0, 1'b0, 16'h0000, "halt_enter");
    for (int i = 0; i < 50; i++) begin
      imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
      ps = 2'($urandom); ir_l = 1'($urandom); ns = 1'($urandom); jump_addr = 16'($urandom);
      clk_step();
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'(m_pc) || ir !== 16'h0F0F ||
          ir_valid !== 1'b0 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold cyc%0d: h=%b req=%b pc=%h ir=%h v=%b e=%b want h=1 req=0 pc=%h ir=0F0F v=0 e=0",
                 i, halted, imem_req, pc, ir, ir_valid, fetch_err, 16'(m_pc));
      end
    end
    imem_ack = 1'b0; ns = 1'b0; ir_l = 1'b0;
    do_reset(1'b0);
    test_reset("halt_reset");
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (imem_req !== 1'b1 || halted !== 1'b0 || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait cyc%0d: req=%b h=%b e=%b want req=1 h=0 e=0", i, imem_req, halted, fetch_err);
      end
      clk_step();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0010 || ir !== 16'h0000) begin
        errors++;
        $display("FAIL to_err cyc%0d: e=%b h=%b req=%b pc=%h ir=%h want e=1 h=1 req=0 pc=0010 ir=0000",
                 i, fetch_err, halted, imem_req, pc, ir);
      end
      imem_ack = 1'b1; imem_rdata = 16'hDEAD;
      clk_step();
      imem_ack = 1'b0;
    end
    do_reset(1'b0);
    test_reset("to_reset");
  endtask

  task automatic test_reset_midfetch();
    fetch_word(0, 16'h5555, "mid_setup");
    exec_step(2'b11, 1'b1, 1'b0, 16'h1234, "mid_jump");
    clk_step();
    clk_step();
    do_reset(1'b1);
    test_reset("mid_fetch_reset");
    fetch_word(1, 16'h6666, "mid_exec_setup");
    exec_step(2'b00, 1'b1, 1'b1, 16'h0000, "mid_exec_hold");
    ps = 2'b11; ir_l = 1'b1; ns = 1'b0; jump_addr = 16'h0999;
    do_reset(1'b0);
    test_reset("mid_exec_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int nhold;
      fetch_word(int'($urandom_range(0, 4)), 16'($urandom), "rnd_fetch");
      nhold = int'($urandom_range(0, 2));
      for (int k = 0; k < nhold; k++)
        exec_step(2'($urandom), 1'($urandom), 1'b1, 16'($urandom), "rnd_hold");
      exec_step(2'($urandom), 1'b1, 1'b0, 16'($urandom), "rnd_exec");
    end
  endtask

  initial begin
    do_reset(1'b0);
    test_reset("reset");
    test_basic();
    test_branch();
    test_multicycle();
    test_halt();
    test_timeout();
    test_reset_midfetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
